// File: rtl/img_fetch_ctrl.sv
// Frame-memory read sequencer feeding a 2-entry valid/ready pixel buffer.
// Optional FRAME_LOOP_EN: wrap at the last address and keep fetching frames.
module img_fetch_ctrl #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 34,
  parameter int NUM_WORDS = 518400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pix,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    DONE
  } st_t;

  typedef struct packed {
    logic [31:0] pix;
    logic        sof;
    logic        eol;
  } ent_t;

  st_t         st, st_n;
  logic [ADDR_W-1:0] cnt_n;
  ent_t        b0, b1, wr;
  logic [1:0]  n;
  logic        full, empty, pop, push;
  logic        wvld, empty_nx;
`ifdef FRAME_LOOP_EN
  logic        wrap_n, wrap_q;
`endif

  assign wvld  = data[DATA_W-1];
  assign full  = (n == 2'd2);
  assign empty = (n == 2'd0);
  assign pop   = !empty && out_ready;
  assign push  = (st == FETCH) && wvld
              && (!full || pop);
  assign empty_nx = empty
                 || ((n == 2'd1) && pop);

  assign wr.pix = data[31:0];
  assign wr.sof = (count == '0);
  assign wr.eol = data[DATA_W-2];

  assign out_valid = !empty;
  assign out_pix   = b0.pix;
  assign out_sof   = b0.sof;
  assign out_eol   = b0.eol;
  assign busy      = (st != IDLE);
`ifdef FRAME_LOOP_EN
  assign done      = (st == DONE) || wrap_q;
`else
  assign done      = (st == DONE);
`endif

  always_comb begin
    st_n  = st;
    cnt_n = count;
`ifdef FRAME_LOOP_EN
    wrap_n = 1'b0;
`endif
    unique case (st)
      IDLE: if (start) st_n = FETCH;
      FETCH: begin
        if (!wvld) begin
          st_n = FLUSH;
        end else if (push) begin
          if (count == LAST) begin
`ifdef FRAME_LOOP_EN
            cnt_n  = '0;
            wrap_n = 1'b1;
`else
            st_n = FLUSH;
`endif
          end else begin
            cnt_n = count + 1'b1;
          end
        end
      end
      FLUSH: if (empty_nx) st_n = DONE;
      DONE: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      count <= '0;
`ifdef FRAME_LOOP_EN
      wrap_q <= 1'b0;
`endif
    end else begin
      st    <= st_n;
      count <= cnt_n;
`ifdef FRAME_LOOP_EN
      wrap_q <= wrap_n;
`endif
    end
  end

  // head is b0; a push lands in the first free slot after any pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b0 <= '0;
      b1 <= '0;
      n  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (empty) b0 <= wr;
          else       b1 <= wr;
          n <= n + 2'd1;
        end
        2'b01: begin
          b0 <= b1;
          n  <= n - 2'd1;
        end
        2'b11: begin
          if (n == 2'd1) begin
            b0 <= wr;
          end else begin
            b0 <= b1;
            b1 <= wr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_fetch_ctrl.sv
// Directed bench for img_fetch_ctrl with a small combinational memory.
// Build with FRAME_LOOP_EN defined to exercise the looping variant.
module tb_img_fetch_ctrl;

`ifdef FRAME_LOOP_EN
  localparam int NW = 4;
`else
  localparam int NW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [21:0] count;
  logic [33:0] data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pix;
  logic        out_sof;
  logic        out_eol;
  logic        busy;
  logic        done;

  logic [33:0] mem [0:7];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data = mem[count[2:0]];

  img_fetch_ctrl #(
    .ADDR_W(22),
    .DATA_W(34),
    .NUM_WORDS(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .count(count),
    .data(data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix(out_pix),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 8; i++)
      mem[i] = {1'b1, (i == 3 || i == 7),
                32'(i) * 32'h01010101};
  endtask

  // mode 0: ready high; mode 1: toggle, then stall 5 cycles
  // spur 1: extra starts mid-frame; spur 2: start in DONE
  task automatic run_frame(input int mode,
                           input int nexp,
                           input bit full,
                           input int spur);
    int idx = 0;
    int cyc = 0;
    int last_acc = -10;
    int done_cyc = -1;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [31:0] pp = '0;
    logic [21:0] pc = '0;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_t0", busy, 1);
    chk("cnt_t0", count, 0);
    chk("valid_t0", out_valid, 0);
    while (done_cyc < 0 && cyc < 200) begin
      if (mode == 0) out_ready = 1'b1;
      else if (cyc < 8) out_ready = (cyc % 2 == 0);
      else if (cyc < 13) out_ready = 1'b0;
      else out_ready = 1'b1;
      start = (spur == 1) && (cyc == 3 || cyc == 6);
      if (mode == 0 && cyc == 1)
        chk("latency", out_valid, 1);
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_pix", out_pix, pp);
      end
      if (mode == 1 && cyc >= 10 && cyc < 13)
        chk("stall_cnt", count, pc);
      if (done) begin
        done_cyc = cyc;
        if (spur == 2) start = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk("pix", out_pix, 32'(idx) * 32'h01010101);
        chk("sof", out_sof, idx == 0);
        chk("eol", out_eol, idx == 3 || idx == 7);
        idx++;
        last_acc = cyc;
      end
      pv = out_valid;
      pr = out_ready;
      pp = out_pix;
      pc = count;
      step;
      cyc++;
    end
    start = 1'b0;
    chk("timeout", done_cyc >= 0, 1);
    chk("nwords", idx, nexp);
    if (full) chk("done_lat", done_cyc - last_acc, 1);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("cnt_end", count, 0);
    step;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int nd;
    init_mem();
    rst_n = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    step;
    step;
    chk("rst_cnt", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", out_pix, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step;
`ifdef FRAME_LOOP_EN
    nd = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int t = 0; t < 14; t++) begin
      chk("loop_cnt", count, t % 4);
      if (t >= 1) begin
        chk("loop_valid", out_valid, 1);
        chk("loop_pix", out_pix,
            32'((t - 1) % 4) * 32'h01010101);
        chk("loop_sof", out_sof, (t - 1) % 4 == 0);
      end
      if (done) nd++;
      step;
    end
    chk("loop_done", nd, 3);
    chk("loop_busy", busy, 1);
`else
    run_frame(0, 8, 1'b1, 0);
    run_frame(1, 8, 1'b1, 0);
    mem[5][33] = 1'b0;
    run_frame(0, 5, 1'b0, 0);
    init_mem();
    run_frame(0, 8, 1'b1, 0);
    run_frame(0, 8, 1'b1, 1);
    run_frame(0, 8, 1'b1, 2);
    out_ready = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    step;
    chk("mid_valid", out_valid, 1);
`endif
    rst_n = 1'b0;
    step;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pix", out_pix, 0);
    chk("mrst_sof", out_sof, 0);
    chk("mrst_eol", out_eol, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_cnt", count, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step;
    chk("post_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
